// File: rtl/crossbar_2x2.sv
// crossbar_2x2
//   2x2 switching cell for multi-stage interconnects (Benes/butterfly).
//   Two WIDTH-bit lanes are routed straight or crossed under one select bit.
//   The result is registered, so latency is one clk cycle.
//
//   Datapath:
//     stage A: a 1-to-2 demux per input. The unselected leg is driven to zero.
//     stage B: a 2-to-1 mux per output. Each mux picks the active demux leg
//              that heads for that output.
//     stage C: output register with synchronous active-high reset.
//
// Ports
//   clk      rising-edge clock
//   rst      synchronous reset, active high. Outputs clear to zero.
//   in1,in2  data lanes
//   control  0 = cross (out1<-in2, out2<-in1), 1 = straight (out1<-in1, out2<-in2)
//   out1,out2 registered output lanes

// 1-to-2 demux for one input lane.
// leg_same goes to the output with the same index as the input.
// leg_other goes to the opposite output.
module crossbar_2x2_demux #(
   parameter int WIDTH = 4
) (
   input  logic             sel_straight,
   input  logic [WIDTH-1:0] data,
   output logic [WIDTH-1:0] leg_same,
   output logic [WIDTH-1:0] leg_other
);
   assign leg_same  = sel_straight ? data : '0;
   assign leg_other = sel_straight ? '0   : data;
endmodule

// 2-to-1 mux for one output lane.
module crossbar_2x2_mux #(
   parameter int WIDTH = 4
) (
   input  logic             sel_straight,
   input  logic [WIDTH-1:0] from_same,
   input  logic [WIDTH-1:0] from_other,
   output logic [WIDTH-1:0] data
);
   assign data = sel_straight ? from_same : from_other;
endmodule

module crossbar_2x2 #(
   parameter int WIDTH = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] in1,
   input  logic [WIDTH-1:0] in2,
   input  logic             control,
   output logic [WIDTH-1:0] out1,
   output logic [WIDTH-1:0] out2
);
   // Index 0 is lane 1 and index 1 is lane 2.
   logic [1:0][WIDTH-1:0] lane_in;
   logic [1:0][WIDTH-1:0] leg_same;
   logic [1:0][WIDTH-1:0] leg_other;
   logic [1:0][WIDTH-1:0] lane_nxt;
   logic [1:0][WIDTH-1:0] lane_q;

   assign lane_in[0] = in1;
   assign lane_in[1] = in2;

   genvar i;
   generate
      for (i = 0; i < 2; i++) begin : g_lane
         crossbar_2x2_demux #(.WIDTH(WIDTH)) u_demux (
            .sel_straight (control),
            .data         (lane_in[i]),
            .leg_same     (leg_same[i]),
            .leg_other    (leg_other[i])
         );

         // Output i takes either its own input's straight leg
         // or the opposite input's cross leg.
         crossbar_2x2_mux #(.WIDTH(WIDTH)) u_mux (
            .sel_straight (control),
            .from_same    (leg_same[i]),
            .from_other   (leg_other[1-i]),
            .data         (lane_nxt[i])
         );
      end
   endgenerate

   always_ff @(posedge clk) begin
      if (rst) lane_q <= '0;
      else     lane_q <= lane_nxt;
   end

   assign out1 = lane_q[0];
   assign out2 = lane_q[1];
endmodule

// File: tb/tb_crossbar_2x2.sv
module tb_crossbar_2x2;
   localparam int W = 4;

   logic         clk = 1'b0;
   logic         rst;
   logic [W-1:0] in1, in2;
   logic         control;
   logic [W-1:0] out1, out2;

   int checks = 0;
   int errors = 0;

   crossbar_2x2 #(.WIDTH(W)) dut (
      .clk     (clk),
      .rst     (rst),
      .in1     (in1),
      .in2     (in2),
      .control (control),
      .out1    (out1),
      .out2    (out2)
   );

   always #5 clk = ~clk;

   // Reference model. The outputs are a permutation of the inputs:
   // straight keeps the lane order, and cross swaps it. Reset gives zero.
   // One expected pair is queued per rising edge.
   logic [2*W-1:0] exp_q[$];

   function automatic logic [2*W-1:0] route(input logic r, input logic c,
                                           input logic [W-1:0] a, input logic [W-1:0] b);
      logic [W-1:0] src [2];
      logic [W-1:0] dst [2];
      src[0] = a;
      src[1] = b;
      for (int j = 0; j < 2; j++) dst[j] = r ? '0 : src[c ? j : 1 - j];
      return {dst[0], dst[1]};
   endfunction

   always @(posedge clk) exp_q.push_back(route(rst, control, in1, in2));

   // Compare on the falling edge, after the output register has settled.
   always @(negedge clk) begin
      logic [2*W-1:0] e;
      if (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         checks++;
         if ({out1, out2} !== e) begin
            errors++;
            $display("FAIL model t=%0t out1/out2 got %h/%h want %h/%h",
                     $time, out1, out2, e[2*W-1:W], e[W-1:0]);
         end
      end
   end

   // Drive the inputs, wait for one rising edge, and let the register settle.
   task automatic cyc(input logic r, input logic c, input logic [W-1:0] a, input logic [W-1:0] b);
      rst = r; control = c; in1 = a; in2 = b;
      @(posedge clk);
      #1;
   endtask

   task automatic lit(input string name, input logic [W-1:0] e1, input logic [W-1:0] e2);
      checks++;
      if (out1 !== e1 || out2 !== e2) begin
         errors++;
         $display("FAIL %s got %h/%h want %h/%h", name, out1, out2, e1, e2);
      end
   endtask

   initial begin
      logic [W-1:0] a, b;
      logic c;
      rst = 1'b1; control = 1'b0; in1 = '0; in2 = '0;
      #2;

      // Reset holds the outputs at zero even while the inputs are non-zero.
      cyc(1'b1, 1'b1, 4'hA, 4'h5);  lit("reset_edge1", 4'h0, 4'h0);
      cyc(1'b1, 1'b1, 4'hA, 4'h5);  lit("reset_edge2", 4'h0, 4'h0);
      cyc(1'b0, 1'b1, 4'hA, 4'h5);  lit("reset_release", 4'hA, 4'h5);

      cyc(1'b0, 1'b0, 4'h0, 4'h1);  lit("cross", 4'h1, 4'h0);
      cyc(1'b0, 1'b1, 4'h3, 4'hC);  lit("straight", 4'h3, 4'hC);

      // Change control (0 -> 1) and both data lanes on the same edge.
      cyc(1'b0, 1'b0, 4'h6, 4'h9);  lit("simul_pre", 4'h9, 4'h6);
      cyc(1'b0, 1'b1, 4'hE, 4'h7);  lit("simul_post", 4'hE, 4'h7);

      // Sweep: the inputs count up, and control toggles every cycle for the
      // first 4 cycles, then every second cycle. Reset is pulsed on cycle 9.
      a = 4'h0; b = 4'h1; c = 1'b0;
      for (int k = 0; k < 16; k++) begin
         cyc(k == 9, c, a, b);
         if (k == 9)      lit("sweep_midreset", 4'h0, 4'h0);
         else if (c)      lit("sweep_straight", a, b);
         else             lit("sweep_cross", b, a);
         a++; b++;
         if (k < 4 || k[0]) c = ~c;
      end

      // Random traffic, with an occasional reset.
      for (int k = 0; k < 300; k++)
         cyc(($urandom_range(0, 19) == 0), $urandom_range(0, 1),
             W'($urandom), W'($urandom));

      @(negedge clk);
      #1;
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
